// File: rtl/dmem_responder.sv
// Data-memory responder for a pipelined core: services one load or store at a time
// with a fixed wait latency, holding the pipeline via dmem_stall until the DONE cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_dmem_we,
  input  logic        m_dmem_re,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_dmem_wd,
  output logic [31:0] m_dmem_rd,
  output logic        dmem_stall,
  output logic        dmem_error,
  output logic [1:0]  o_dbg_state
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_op_we;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wd;
  logic [31:0]      r_rd;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic w_req;
  logic w_illegal;
  logic w_finish;
  logic w_commit;

  assign w_req     = m_dmem_we | m_dmem_re;
  assign w_illegal = (m_alu_out[1:0] != 2'b00) ||
                     ({2'b00, m_alu_out[31:2]} >= 32'(DEPTH_WORDS));
  assign w_finish  = (r_state == S_BUSY) && (r_cnt == 4'd0);
  // Store commits only on the BUSY->DONE edge; reset forces IDLE first, so an
  // in-flight store is dropped if reset lands before that edge.
  assign w_commit  = w_finish && r_op_we;

  assign dmem_stall  = ((r_state == S_IDLE) && w_req) || (r_state == S_BUSY);
  assign m_dmem_rd   = r_rd;
  assign dmem_error  = r_err;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op_we <= 1'b0;
      r_idx   <= '0;
      r_wd    <= 32'd0;
      r_rd    <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_illegal) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_rd    <= 32'd0;
            end else begin
              r_state <= S_BUSY;
              r_op_we <= m_dmem_we;
              r_idx   <= m_alu_out[IDX_W+1:2];
              r_wd    <= m_dmem_wd;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_DONE;
            if (!r_op_we) begin
              r_rd <= r_mem[r_idx];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset: contents survive reset and start unspecified.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wd;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 15) on
// independent request buses sharing clock and reset.
module tb_dmem_responder;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk;
  logic        reset_n;
  logic        we    [3];
  logic        re    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rd    [3];
  logic        stall [3];
  logic        err   [3];
  logic [1:0]  dst   [3];

  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .m_dmem_we(we[0]), .m_dmem_re(re[0]),
    .m_alu_out(addr[0]), .m_dmem_wd(wd[0]), .m_dmem_rd(rd[0]),
    .dmem_stall(stall[0]), .dmem_error(err[0]), .o_dbg_state(dst[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .m_dmem_we(we[1]), .m_dmem_re(re[1]),
    .m_alu_out(addr[1]), .m_dmem_wd(wd[1]), .m_dmem_rd(rd[1]),
    .dmem_stall(stall[1]), .dmem_error(err[1]), .o_dbg_state(dst[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset_n(reset_n), .m_dmem_we(we[2]), .m_dmem_re(re[2]),
    .m_alu_out(addr[2]), .m_dmem_wd(wd[2]), .m_dmem_rd(rd[2]),
    .dmem_stall(stall[2]), .dmem_error(err[2]), .o_dbg_state(dst[2])
  );

  // ---------------- driver ----------------
  // Presents a request on a negedge, holds it while stall is high, then samples
  // outputs in the first stall-low (DONE) cycle and releases the request.
  // ns = -1 means stall never dropped within the budget.
  task automatic access(input int d, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] data,
                        output int ns, output logic [31:0] rdv,
                        output logic ev, output logic [1:0] stv);
    int n;
    @(negedge clk);
    we[d] = w; re[d] = r; addr[d] = a; wd[d] = data;
    #1;
    n = 0;
    while (stall[d] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    ns  = (n >= 40) ? -1 : n;
    rdv = rd[d];
    ev  = err[d];
    stv = dst[d];
    we[d] = 1'b0; re[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rd[0] !== 32'd0 || err[0] !== 1'b0 || stall[0] !== 1'b0 || dst[0] !== S_IDLE) begin
      n_errors++;
      $display("FAIL reset_held: rd=%h err=%b stall=%b st=%0d required rd=0 err=0 stall=0 st=0",
               rd[0], err[0], stall[0], dst[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (rd[0] !== 32'd0 || err[0] !== 1'b0 || stall[0] !== 1'b0 || dst[0] !== S_IDLE) begin
      n_errors++;
      $display("FAIL reset_released: rd=%h err=%b stall=%b st=%0d required all 0",
               rd[0], err[0], stall[0], dst[0]);
    end
  endtask

  task automatic test_store_load();
    int ns; logic [31:0] v; logic e; logic [1:0] s;
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, ns, v, e, s);
    n_checks++;
    if (ns !== 3 || e !== 1'b0 || s !== S_DONE) begin
      n_errors++;
      $display("FAIL store_0x10: stall=%0d err=%b st=%0d required stall=3 err=0 st=2", ns, e, s);
    end
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, ns, v, e, s);
    n_checks++;
    if (ns !== 3 || v !== 32'hDEADBEEF || e !== 1'b0) begin
      n_errors++;
      $display("FAIL load_0x10: stall=%0d rd=%h err=%b required stall=3 rd=deadbeef err=0", ns, v, e);
    end
  endtask

  task automatic test_store_priority();
    int ns; logic [31:0] v; logic e; logic [1:0] s;
    access(0, 1'b1, 1'b0, 32'h18, 32'hAAAA0000, ns, v, e, s);
    access(0, 1'b0, 1'b1, 32'h18, 32'h0, ns, v, e, s);
    n_checks++;
    if (v !== 32'hAAAA0000) begin
      n_errors++;
      $display("FAIL preload_rd: rd=%h required aaaa0000", v);
    end
    access(0, 1'b1, 1'b1, 32'h14, 32'h12345678, ns, v, e, s);
    n_checks++;
    if (ns !== 3 || v !== 32'hAAAA0000 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL we_re_both: stall=%0d rd=%h err=%b required stall=3 rd=aaaa0000 err=0", ns, v, e);
    end
    access(0, 1'b0, 1'b1, 32'h14, 32'h0, ns, v, e, s);
    n_checks++;
    if (v !== 32'h12345678) begin
      n_errors++;
      $display("FAIL readback_0x14: rd=%h required 12345678", v);
    end
  endtask

  task automatic test_illegal();
    int ns; logic [31:0] v; logic e; logic [1:0] s;
    access(0, 1'b0, 1'b1, 32'h13, 32'h0, ns, v, e, s);
    n_checks++;
    if (ns !== 1 || e !== 1'b1 || v !== 32'd0 || s !== S_DONE) begin
      n_errors++;
      $display("FAIL illegal_misaligned: stall=%0d err=%b rd=%h st=%0d required stall=1 err=1 rd=0 st=2",
               ns, e, v, s);
    end
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, ns, v, e, s);
    access(0, 1'b1, 1'b0, 32'h400, 32'h0BADF00D, ns, v, e, s);
    n_checks++;
    if (ns !== 1 || e !== 1'b1 || v !== 32'd0) begin
      n_errors++;
      $display("FAIL illegal_range_0x400: stall=%0d err=%b rd=%h required stall=1 err=1 rd=0", ns, e, v);
    end
    // Index 0x104 would alias onto word 0x10 if the range check were truncated.
    access(0, 1'b1, 1'b0, 32'h410, 32'hBAD0BAD0, ns, v, e, s);
    n_checks++;
    if (ns !== 1 || e !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_range_0x410: stall=%0d err=%b required stall=1 err=1", ns, e);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (err[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL error_clears: err=%b required 0", err[0]);
    end
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, ns, v, e, s);
    n_checks++;
    if (v !== 32'hDEADBEEF || e !== 1'b0) begin
      n_errors++;
      $display("FAIL word_0x10_intact: rd=%h err=%b required deadbeef err=0", v, e);
    end
  endtask

  task automatic test_reset_mid();
    int ns; logic [31:0] v; logic e; logic [1:0] s;
    access(0, 1'b1, 1'b0, 32'h20, 32'h1, ns, v, e, s);
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, ns, v, e, s);
    n_checks++;
    if (v !== 32'h1) begin
      n_errors++;
      $display("FAIL pre_reset_load: rd=%h required 00000001", v);
    end
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h55;
    @(negedge clk);
    #1;
    n_checks++;
    if (dst[0] !== S_BUSY || stall[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_store_busy: st=%0d stall=%b required st=1 stall=1", dst[0], stall[0]);
    end
    reset_n = 1'b0;
    we[0] = 1'b0;
    #1;
    n_checks++;
    if (rd[0] !== 32'd0 || err[0] !== 1'b0 || stall[0] !== 1'b0 || dst[0] !== S_IDLE) begin
      n_errors++;
      $display("FAIL async_reset: rd=%h err=%b stall=%b st=%0d required all 0",
               rd[0], err[0], stall[0], dst[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, ns, v, e, s);
    n_checks++;
    if (ns !== 3 || v !== 32'h1) begin
      n_errors++;
      $display("FAIL abandoned_store: stall=%0d rd=%h required stall=3 rd=00000001", ns, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_pat;
    exp_pat = 8'b1110_1110;
    @(negedge clk);
    re[0] = 1'b1; addr[0] = 32'h10;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (stall[0] !== exp_pat[7-i]) begin
        n_errors++;
        $display("FAIL b2b_stall_cycle%0d: stall=%b required %b", i, stall[0], exp_pat[7-i]);
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (rd[0] !== 32'hDEADBEEF || dst[0] !== S_DONE) begin
          n_errors++;
          $display("FAIL b2b_done_cycle%0d: rd=%h st=%0d required rd=deadbeef st=2", i, rd[0], dst[0]);
        end
      end
      @(negedge clk);
    end
    re[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int ns; logic [31:0] v; logic e; logic [1:0] s;
    access(1, 1'b1, 1'b0, 32'h8, 32'hCAFE0001, ns, v, e, s);
    n_checks++;
    if (ns !== 2 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lat1_store: stall=%0d err=%b required stall=2 err=0", ns, e);
    end
    access(1, 1'b0, 1'b1, 32'h8, 32'h0, ns, v, e, s);
    n_checks++;
    if (ns !== 2 || v !== 32'hCAFE0001) begin
      n_errors++;
      $display("FAIL lat1_load: stall=%0d rd=%h required stall=2 rd=cafe0001", ns, v);
    end
    access(2, 1'b1, 1'b0, 32'h3FC, 32'h0F0F1234, ns, v, e, s);
    n_checks++;
    if (ns !== 16 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lat15_store: stall=%0d err=%b required stall=16 err=0", ns, e);
    end
    access(2, 1'b0, 1'b1, 32'h3FC, 32'h0, ns, v, e, s);
    n_checks++;
    if (ns !== 16 || v !== 32'h0F0F1234) begin
      n_errors++;
      $display("FAIL lat15_load: stall=%0d rd=%h required stall=16 rd=0f0f1234", ns, v);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; re[i] = 1'b0; addr[i] = 32'd0; wd[i] = 32'd0;
    end
    test_reset();
    test_store_load();
    test_store_priority();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_latency();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, the number of 32-bit data words held internally.
REQ-002 SHALL provide parameter LATENCY, default 2, the number of wait cycles spent in BUSY (legal range 1..15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; these are fixed.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port m_dmem_we, input, 1 bit: memory-stage store request.
REQ-007 SHALL have port m_dmem_re, input, 1 bit: memory-stage load request.
REQ-008 SHALL have port m_alu_out, input, 32 bits: byte address.
REQ-009 SHALL have port m_dmem_wd, input, 32 bits: store data.
REQ-010 SHALL have port m_dmem_rd, output, 32 bits: load data toward the writeback pipeline register.
REQ-011 SHALL have port dmem_stall, output, 1 bit: pipeline hold, high while the access is incomplete.
REQ-012 SHALL have port dmem_error, output, 1 bit: the completed access was rejected.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE, plus a 4-bit wait counter.
REQ-014 SHALL treat a request as present when m_dmem_we | m_dmem_re; if both are high, the store takes priority and no load is performed.
REQ-015 SHALL treat an address as illegal when m_alu_out[1:0] != 0 or m_alu_out[31:2] >= DEPTH_WORDS; the word index is m_alu_out[31:2].
REQ-016 SHALL, in IDLE with a legal request, latch the operation, index and store data, load counter = LATENCY-1, and go to BUSY.
REQ-017 SHALL, in IDLE with an illegal request, go directly to DONE with the error flag set, without latching store data.
REQ-018 SHALL, in IDLE with no request, remain in IDLE.
REQ-019 SHALL, in BUSY, decrement the counter while it is nonzero, and transition to DONE on the edge where it is 0.
REQ-020 SHALL commit a store to the array on the BUSY->DONE edge only.
REQ-021 SHALL register the array word into m_dmem_rd on the BUSY->DONE edge for a load.
REQ-022 SHALL go from DONE to IDLE unconditionally and ignore request inputs during DONE.
REQ-023 SHALL drive dmem_stall combinationally: high in IDLE when a request is present, high in BUSY, low in DONE and in idle-without-request.
REQ-024 SHALL give a legal access LATENCY+1 stall cycles, with the result valid in the DONE cycle (cycle LATENCY+1 after presentation).
REQ-025 SHALL give an illegal access exactly 1 stall cycle.
REQ-026 SHALL hold m_dmem_rd between loads; a store leaves it unchanged; an illegal access sets it to 0 on entry to DONE.
REQ-027 SHALL assert dmem_error only in the DONE cycle of an illegal access, and 0 otherwise.
REQ-028 SHALL rely on the initiator holding m_dmem_we/re, m_alu_out and m_dmem_wd stable while dmem_stall is high; the latched copies are used regardless.
REQ-029 SHALL, for back-to-back requests, accept the next request no earlier than the cycle after DONE (the initiator's pipeline advances at the end of DONE).

Reset
REQ-030 SHALL, on reset_n low, immediately force state IDLE, counter 0, m_dmem_rd 0, dmem_error 0, and latched registers 0; dmem_stall then follows REQ-023 from IDLE.
REQ-031 SHALL leave array contents unaffected by reset, with initial contents unspecified.
REQ-032 SHALL abandon an in-flight store when reset asserts before the BUSY->DONE edge, leaving the array word unmodified.
REQ-033 SHALL begin accepting requests on the first rising edge after reset_n deasserts.

Verification
REQ-034 SHALL test a LATENCY=2 store: we=1, addr 0x10, wd 0xDEADBEEF -> stall high 3 cycles, low in DONE; then re=1 at 0x10 -> m_dmem_rd 0xDEADBEEF in its DONE cycle, error 0.
REQ-035 SHALL test we=re=1 at 0x14 with wd 0x12345678 where m_dmem_rd is previously 0xAAAA0000 -> word 0x14 becomes 0x12345678 and m_dmem_rd stays 0xAAAA0000.
REQ-036 SHALL test illegal accesses: re=1 at 0x13, then we=1 at 0x400 -> each gives stall 1 cycle, error 1 in DONE, m_dmem_rd 0, and word 0x10 still 0xDEADBEEF.
REQ-037 SHALL test reset mid-operation: word 0x20 = 0x1, store 0x55 to 0x20, reset_n pulsed low in BUSY -> outputs 0 immediately and later readback returns 0x1.
REQ-038 SHALL test back-to-back requests: requests held continuously across two accesses -> second accepted the cycle after DONE, with a 1-cycle stall-low gap between 3-cycle stall bursts.
REQ-039 SHALL test LATENCY=1 and LATENCY=15 builds with a store/load pair -> stall lengths of 2 and 16 cycles, with data correct.
